// File: rtl/hack_video_pkg.sv
// Shared screen geometry, default raster timing and address type for the Hack video path.
// The SCANOUT_LINE_DOUBLE_EN option is handled in hack_screen_scanout.
package hack_video_pkg;

  localparam int SCREEN_WORDS    = 8192;
  localparam int WORDS_PER_ROW   = 32;
  localparam int PIXELS_PER_WORD = 16;
  localparam int ADDR_W          = 13;

  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 64;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 16;

  typedef logic [ADDR_W-1:0] screen_addr_t;

  // Row-major word address of the word that holds pixel column pix of screen row row.
  function automatic screen_addr_t word_addr(input logic [31:0] row, input logic [31:0] pix);
    return screen_addr_t'(row * WORDS_PER_ROW + pix / PIXELS_PER_WORD);
  endfunction

endpackage

// File: rtl/hack_video_timing.sv
// Raster counters plus registered de/hsync/vsync/frame_start; hcount, vcount and the
// combinational visible flag are exported so the fetch path can align to them.
module hack_video_timing
  import hack_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_LINES  = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_LINES + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          active,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);

  logic hsync_on;
  logic vsync_on;

  // Reset parks the counters two clocks before row 0 so the first fetch is issued at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= HW'(H_TOTAL - 2);
      vcount <= VW'(V_TOTAL - 1);
    end else if (hcount == HW'(H_TOTAL - 1)) begin
      hcount <= '0;
      vcount <= (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  always_comb begin
    active   = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_LINES));
    hsync_on = (hcount >= HW'(H_ACTIVE + H_FP)) && (hcount < HW'(H_ACTIVE + H_FP + H_SYNC));
    vsync_on = (vcount >= VW'(V_LINES + V_FP)) && (vcount < VW'(V_LINES + V_FP + V_SYNC));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      de          <= active;
      hsync       <= hsync_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vsync_on ? SYNC_POL : ~SYNC_POL;
      frame_start <= (hcount == '0) && (vcount == '0);
    end
  end

endmodule

// File: rtl/hack_screen_scanout.sv
// Screen RAM read-side scan-out: fetches one word per 16 pixels and serialises it LSB first.
// Define SCANOUT_LINE_DOUBLE_EN to show every screen row on two consecutive lines.
module hack_screen_scanout
  import hack_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  output logic         rd_en,
  output screen_addr_t rd_addr,
  input  logic [15:0]  rd_data,
  output logic         pixel,
  output logic         de,
  output logic         hsync,
  output logic         vsync,
  output logic         frame_start
);

`ifdef SCANOUT_LINE_DOUBLE_EN
  localparam int LINE_SHIFT = 1;
`else
  localparam int LINE_SHIFT = 0;
`endif
  localparam int V_LINES = V_ACTIVE << LINE_SHIFT;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_LINES + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          active;
  logic [31:0]   p_next;
  logic [31:0]   line_next;
  logic [31:0]   row_next;
  logic          fetch_hit;
  logic [15:0]   shreg;

  hack_video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_LINES  (V_LINES),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clock       (clock),
    .reset_n     (reset_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .active      (active),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  // Look two pixels ahead: one clock for the read strobe register, one for RAM latency.
  always_comb begin
    p_next    = 32'(hcount) + 32'd2;
    line_next = 32'(vcount);
    if (p_next >= 32'(H_TOTAL)) begin
      p_next    = p_next - 32'(H_TOTAL);
      line_next = (line_next == 32'(V_TOTAL - 1)) ? 32'd0 : line_next + 32'd1;
    end
    row_next  = line_next >> LINE_SHIFT;
    fetch_hit = (p_next < 32'(H_ACTIVE)) && (p_next[3:0] == 4'd0) && (line_next < 32'(V_LINES));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= fetch_hit;
      if (fetch_hit) begin
        rd_addr <= word_addr(row_next, p_next);
      end
    end
  end

  // Word boundary loads the fresh RAM word; bit 0 goes straight out as the leftmost pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      pixel <= 1'b0;
    end else if (active && (hcount[3:0] == 4'd0)) begin
      pixel <= rd_data[0];
      shreg <= {1'b0, rd_data[15:1]};
    end else if (active) begin
      pixel <= shreg[0];
      shreg <= shreg >> 1;
    end else begin
      pixel <= 1'b0;
    end
  end

endmodule
